// File: rtl/bcd_seven_segment.sv
// bcd_seven_segment: registered BCD to 7-segment decoder with lamp test, blanking and invalid flag
module bcd_seven_segment #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] display,
  output logic       invalid
);
  localparam logic [6:0] POL = {7{ACTIVE_LOW}};
  logic [6:0] pattern, display_d, display_q;
  logic       invalid_d, invalid_q;
  always_comb begin
    case (bcd)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1111011;
      default: pattern = 7'b0000000;
    endcase
    invalid_d = bcd > 4'd9;
    display_d = (lamp_test ? 7'b1111111 : blank ? 7'b0000000 : pattern) ^ POL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      display_q <= POL;
      invalid_q <= 1'b0;
    end else begin
      display_q <= display_d;
      invalid_q <= invalid_d;
    end
  assign display = display_q;
  assign invalid = invalid_q;
endmodule

// File: tb/tb_bcd_seven_segment.sv
// tb_bcd_seven_segment: table vectors, corner sequences and random stimulus against a reference model
module tb_bcd_seven_segment;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] display, display_al;
  logic       invalid, invalid_al;
  int         passed = 0;
  int         total = 0;

  bcd_seven_segment #(.ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
    .display(display), .invalid(invalid)
  );
  bcd_seven_segment #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
    .display(display_al), .invalid(invalid_al)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bcd;
    logic       blank;
    logic       lt;
    logic [6:0] disp;
    logic       inv;
  } vec_t;

  logic [6:0] digit_seg [10];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic logic [6:0] model(input logic [3:0] b, input logic bl, input logic lt);
    if (lt) return 7'h7f;
    if (bl || b > 9) return 7'h00;
    return digit_seg[b];
  endfunction

  task automatic step(input logic [3:0] b, input logic bl, input logic lt);
    @(negedge clk);
    bcd = b;
    blank = bl;
    lamp_test = lt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [6:0] exp_disp, input logic exp_inv);
    chk({name, " display"}, display, exp_disp);
    chk({name, " display_al"}, display_al, ~exp_disp);
    chk({name, " invalid"}, {6'd0, invalid}, {6'd0, exp_inv});
    chk({name, " invalid_al"}, {6'd0, invalid_al}, {6'd0, exp_inv});
  endtask

  vec_t vecs [$];

  initial begin
    digit_seg = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    vecs.push_back('{4'd1, 1'b0, 1'b0, 7'b0110000, 1'b0});
    vecs.push_back('{4'd3, 1'b0, 1'b0, 7'b1111001, 1'b0});
    vecs.push_back('{4'd8, 1'b0, 1'b0, 7'b1111111, 1'b0});
    vecs.push_back('{4'd9, 1'b0, 1'b0, 7'b1111011, 1'b0});
    vecs.push_back('{4'd0, 1'b0, 1'b0, 7'b1111110, 1'b0});
    vecs.push_back('{4'd2, 1'b0, 1'b0, 7'b1101101, 1'b0});
    vecs.push_back('{4'd4, 1'b0, 1'b0, 7'b0110011, 1'b0});
    vecs.push_back('{4'd5, 1'b0, 1'b0, 7'b1011011, 1'b0});
    vecs.push_back('{4'd6, 1'b0, 1'b0, 7'b1011111, 1'b0});
    vecs.push_back('{4'd7, 1'b0, 1'b0, 7'b1110000, 1'b0});
    for (int i = 10; i < 16; i++) vecs.push_back('{4'(i), 1'b0, 1'b0, 7'b0000000, 1'b1});
    vecs.push_back('{4'd5, 1'b0, 1'b1, 7'b1111111, 1'b0});
    vecs.push_back('{4'd5, 1'b1, 1'b0, 7'b0000000, 1'b0});
    vecs.push_back('{4'd5, 1'b0, 1'b0, 7'b1011011, 1'b0});
    vecs.push_back('{4'd5, 1'b1, 1'b1, 7'b1111111, 1'b0});
    vecs.push_back('{4'hC, 1'b0, 1'b1, 7'b1111111, 1'b1});
    vecs.push_back('{4'hE, 1'b1, 1'b0, 7'b0000000, 1'b1});

    #12;
    chk_all("reset", 7'b0000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].bcd, vecs[i].blank, vecs[i].lt);
      chk_all($sformatf("vec%0d bcd=%0d", i, vecs[i].bcd), vecs[i].disp, vecs[i].inv);
    end

    step(4'd8, 1'b0, 1'b0);
    chk_all("pre-reset 8", 7'b1111111, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 7'b0000000, 1'b0);
    @(posedge clk);
    #1;
    chk_all("held reset", 7'b0000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("after release", 7'b1111111, 1'b0);

    step(4'd3, 1'b0, 1'b0);
    #2;
    bcd = 4'd7;
    blank = 1'b1;
    #1;
    chk_all("mid-cycle change", 7'b1111001, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] b;
      logic bl, lt;
      b  = 4'($urandom_range(0, 15));
      bl = ($urandom_range(0, 3) == 0);
      lt = ($urandom_range(0, 7) == 0);
      step(b, bl, lt);
      chk_all($sformatf("rand%0d bcd=%0d bl=%0b lt=%0b", i, b, bl, lt), model(b, bl, lt), b > 9);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_seven_segment.md
# bcd_seven_segment

Registered BCD-to-seven-segment decoder driving one digit of a 7-segment display. Takes a 4-bit BCD digit and produces the seven segment enables a–g, with lamp-test, blanking and invalid-code flagging. It sits between the digit-selection/counter logic and the display pins. Output is registered on the single system clock.

## Interface
- ACTIVE_LOW, default 0: segment polarity. 0 means a lit segment is 1 (common cathode); 1 means all segment outputs are inverted (common anode), including the reset value.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- bcd  input  4  BCD digit to display; legal values 0–9.
- blank  input  1  when 1, all segments off; overrides the digit.
- lamp_test  input  1  when 1, all segments lit; overrides `blank` and the digit.
- display  output  7  segment drive, bit order {a,b,c,d,e,f,g}: display[6]=a … display[0]=g.
- invalid  output  1  registered flag, 1 when the sampled `bcd` is 10–15.

## Operation
- Segment patterns before polarity, {a..g}:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- Codes 10–15 (4'hA–4'hF):
  - pattern is all-off (0000000).
  - `invalid` is 1.
- Priority, highest first:
  - `lamp_test`: pattern 1111111. `invalid` still reflects `bcd`.
  - `blank`: pattern 0000000. `invalid` still reflects `bcd`.
  - Decode of `bcd`.
- Polarity: with ACTIVE_LOW=1, `display` = ~pattern. `invalid` is always active-high.
- The decode is a pure function of the sampled inputs. No other internal state.

## Timing
- Latency:
  - `display` and `invalid` reflect the inputs sampled at rising edge N.
  - They are valid after edge N and hold until the next edge.
  - Latency is one cycle.
- No handshake. A new digit may be presented every cycle. Throughput is 1 per cycle.
- Reset (rst_n low):
  - Takes effect immediately, with no clock edge required.
  - `display` = all segments off (0000000; 1111111 when ACTIVE_LOW=1).
  - `invalid` = 0.
- Reset release: the first rising edge with rst_n high loads the decoded value.
- Reset asserted mid-operation: outputs go to their reset values asynchronously, and the previous digit is discarded.
- Simultaneous `lamp_test` and `blank`: lamp test wins.
- Inputs changing between edges have no effect on the outputs until the next edge. No glitches propagate to `display`.
- X/Z on `bcd` is not a legal input. Behaviour in that case is undefined.

## Test plan
- Reset, then release; drive bcd=1, 3, 8, 9 for one cycle each, with ACTIVE_LOW=0. Required response, each one cycle after its input:
  - 1 -> display=0110000
  - 3 -> display=1111001
  - 8 -> display=1111111
  - 9 -> display=1111011
  - `invalid`=0 throughout.
- Sweep bcd 0–15. Required response:
  - 0–9 match the table above.
  - 10–15 give display=0000000 with invalid=1, each one cycle later.
- bcd=5 with lamp_test=1 -> display=1111111. Then lamp_test=0 and blank=1 -> display=0000000. Then blank=0 -> display=1011011.
- bcd=8 steady, assert rst_n=0 between clock edges -> display=0000000 and invalid=0 immediately. Release -> display=1111111 after the next edge.
- ACTIVE_LOW=1 instance, bcd=0 -> display=0000001. In reset -> display=1111111.
- bcd=4'hC with lamp_test=1 -> display=1111111 and invalid=1.
